fetch_stage: RTL and testbench

Fetch stage for the 5-stage RISC-V pipeline. Owns PCF, issues one instruction-memory request at a time over a valid/ready request channel, and loads the Fetch→Decode pipeline register (InstrD, PCD, PCPlus4D, ValidD). Consumes StallF, StallD, FlushD and PCSrcE/PCTargetE from the hazard unit and execute stage. Buffers a returned instruction while decode is stalled, and discards in-flight responses after a redirect.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_hold_reg.sv | 27 ++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage of the 5-stage RISC-V pipeline.
package fetch_pkg;

   // Fetch controller states: issue a request, wait for its response, park a
   // response while decode is stalled, or drain a response owed to a squashed PC.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   // addi x0, x0, 0 -- the canonical RISC-V NOP used for decode bubbles.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // PCF value after reset unless the instantiating design overrides it.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequential next PC; wraps modulo 2^32 naturally.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Single-entry buffer that parks an instruction word returned while decode is stalled.
module fetch_hold_reg #(
   parameter int word_width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  clear,
   input  logic [word_width-1:0] load_data,
   output logic                  valid,
   output logic [word_width-1:0] data
);

   // Clear wins over load so a redirect always empties the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, issues one instruction-memory request at a time and
// loads the Fetch->Decode pipeline register, honouring stalls, flushes and redirects.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                   word_width = 32,
   parameter logic [word_width-1:0] RESET_PC  = word_width'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  StallF,
   input  logic                  StallD,
   input  logic                  FlushD,
   input  logic                  PCSrcE,
   input  logic [word_width-1:0] PCTargetE,
   output logic                  imem_req_valid,
   output logic [word_width-1:0] imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_rsp_valid,
   input  logic [word_width-1:0] imem_rsp_data,
   output logic [word_width-1:0] InstrD,
   output logic [word_width-1:0] PCD,
   output logic [word_width-1:0] PCPlus4D,
   output logic                  ValidD
);

   localparam logic [word_width-1:0] NOP_WORD  = word_width'(NOP_INSTR);
   localparam logic [word_width-1:0] PC_STRIDE = word_width'(4);

   fetch_state_t          state;
   fetch_state_t          next_state;
   logic [word_width-1:0] pc_f;
   logic [word_width-1:0] next_pc;
   logic [word_width-1:0] pc_f_plus4;
   logic                  handshake;
   logic                  deliver;
   logic [word_width-1:0] deliver_data;
   logic                  hold_load;
   logic                  hold_clear;
   logic                  hold_valid;
   logic [word_width-1:0] hold_data;

   assign pc_f_plus4     = pc_f + PC_STRIDE;
   assign imem_req_addr  = pc_f;
   assign imem_req_valid = (state == REQ) && !StallF;
   assign handshake      = imem_req_valid && imem_req_ready;

   fetch_hold_reg #(
      .word_width(word_width)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .clear    (hold_clear),
      .load_data(imem_rsp_data),
      .valid    (hold_valid),
      .data     (hold_data)
   );

   // Next-state, next-PC and delivery decisions; a redirect overrides everything else.
   always_comb begin
      next_state   = state;
      next_pc      = pc_f;
      deliver      = 1'b0;
      deliver_data = imem_rsp_data;
      hold_load    = 1'b0;
      hold_clear   = 1'b0;

      case (state)
         REQ: begin
            if (handshake) next_state = WAIT;
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (!StallD) begin
                  deliver    = 1'b1;
                  next_pc    = pc_f_plus4;
                  next_state = REQ;
               end else begin
                  hold_load  = 1'b1;
                  next_state = HOLD;
               end
            end
         end
         HOLD: begin
            if (!StallD && hold_valid) begin
               deliver      = 1'b1;
               deliver_data = hold_data;
               hold_clear   = 1'b1;
               next_pc      = pc_f_plus4;
               next_state   = REQ;
            end
         end
         DROP: begin
            if (imem_rsp_valid) next_state = REQ;
         end
         default: next_state = REQ;
      endcase

      if (PCSrcE) begin
         next_pc    = PCTargetE;
         deliver    = 1'b0;
         hold_load  = 1'b0;
         hold_clear = 1'b1;
         case (state)
            REQ:     next_state = handshake ? DROP : REQ;
            WAIT:    next_state = imem_rsp_valid ? REQ : DROP;
            HOLD:    next_state = REQ;
            DROP:    next_state = imem_rsp_valid ? REQ : DROP;
            default: next_state = REQ;
         endcase
      end
   end

   // Fetch FSM state and the program counter PCF.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= REQ;
         pc_f  <= RESET_PC;
      end else begin
         state <= next_state;
         pc_f  <= next_pc;
      end
   end

   // Fetch->Decode register: flush beats stall, stall beats delivery, otherwise a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         InstrD   <= NOP_WORD;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD <= NOP_WORD;
         ValidD <= 1'b0;
      end else if (StallD) begin
         InstrD   <= InstrD;
         PCD      <= PCD;
         PCPlus4D <= PCPlus4D;
         ValidD   <= ValidD;
      end else if (deliver) begin
         InstrD   <= deliver_data;
         PCD      <= pc_f;
         PCPlus4D <= pc_f_plus4;
         ValidD   <= 1'b1;
      end else begin
         InstrD <= NOP_WORD;
         ValidD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard of expected decode deliveries plus
// point checks on the request channel, redirects, flush and PC wrap-around.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall_f, stall_d, flush_d, pc_src_e;
   logic [31:0] pc_target_e;
   logic        req_valid, req_ready, rsp_valid;
   logic [31:0] req_addr, rsp_data;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d;

   logic        w_req_valid, w_req_ready, w_rsp_valid;
   logic [31:0] w_req_addr, w_rsp_data;
   logic [31:0] w_instr_d, w_pc_d, w_pc_plus4_d;
   logic        w_valid_d;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } delivery_t;

   delivery_t sb[$];
   logic      prev_valid = 1'b0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
      .PCSrcE(pc_src_e), .PCTargetE(pc_target_e),
      .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .InstrD(instr_d), .PCD(pc_d), .PCPlus4D(pc_plus4_d), .ValidD(valid_d)
   );

   fetch_stage #(.word_width(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
      .PCSrcE(1'b0), .PCTargetE(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(w_req_ready),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .InstrD(w_instr_d), .PCD(w_pc_d), .PCPlus4D(w_pc_plus4_d), .ValidD(w_valid_d)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word the memory returns for a given address.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'hABC0_0000 ^ addr;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full REQ->WAIT->deliver transaction at the expected address, zero-latency memory.
   task automatic applyStimulus(input logic [31:0] addr);
      req_ready = 1'b1;
      #1;
      checkOutput("req_valid in REQ", {31'b0, req_valid}, 32'd1);
      checkOutput("req_addr", req_addr, addr);
      tick();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = mem_word(addr);
      sb.push_back('{instr: mem_word(addr), pc: addr});
      #1;
      checkOutput("req_valid in WAIT", {31'b0, req_valid}, 32'd0);
      tick();
      rsp_valid = 1'b0;
   endtask

   // Scoreboard consumer: every rising edge of ValidD is one new decode delivery.
   always @(negedge clk) begin
      if (valid_d === 1'b1 && prev_valid !== 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected delivery pc", pc_d, 32'hFFFF_FFFF);
         end else begin
            delivery_t exp_d;
            exp_d = sb.pop_front();
            checkOutput("sb InstrD", instr_d, exp_d.instr);
            checkOutput("sb PCD", pc_d, exp_d.pc);
            checkOutput("sb PCPlus4D", pc_plus4_d, exp_d.pc + 32'd4);
         end
      end
      prev_valid <= valid_d;
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      reset = 1'b1;
      stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;
      req_ready = 0; rsp_valid = 0; rsp_data = '0;
      w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = '0;
      tick();
      tick();
      checkOutput("reset InstrD", instr_d, 32'h0000_0013);
      checkOutput("reset ValidD", {31'b0, valid_d}, 32'd0);
      checkOutput("reset PCD", pc_d, 32'd0);
      checkOutput("reset PCPlus4D", pc_plus4_d, 32'd0);
      checkOutput("reset req_addr", req_addr, 32'd0);
      reset = 1'b0;

      // Streaming fetch at 0, 4, 8.
      applyStimulus(32'h0);
      applyStimulus(32'h4);
      applyStimulus(32'h8);

      // Response while decode stalled for three cycles -> parked in HOLD.
      req_ready = 1'b1;
      #1;
      checkOutput("hold req_addr", req_addr, 32'hC);
      tick();
      req_ready = 1'b0;
      stall_d   = 1'b1;
      rsp_valid = 1'b1;
      rsp_data  = mem_word(32'hC);
      sb.push_back('{instr: mem_word(32'hC), pc: 32'hC});
      tick();
      rsp_valid = 1'b0;
      req_ready = 1'b1;
      #1;
      checkOutput("no req in HOLD c1", {31'b0, req_valid}, 32'd0);
      tick();
      #1;
      checkOutput("no req in HOLD c2", {31'b0, req_valid}, 32'd0);
      checkOutput("ValidD during stall", {31'b0, valid_d}, 32'd0);
      tick();
      stall_d   = 1'b0;
      req_ready = 1'b0;
      #1;
      checkOutput("no req in HOLD c3", {31'b0, req_valid}, 32'd0);
      tick();
      checkOutput("HOLD delivered ValidD", {31'b0, valid_d}, 32'd1);

      // Redirect after acceptance, before the response -> DROP the stale response.
      req_ready = 1'b1;
      #1;
      checkOutput("drop req_addr", req_addr, 32'h10);
      tick();
      req_ready   = 1'b0;
      pc_src_e    = 1'b1;
      pc_target_e = 32'h40;
      tick();
      pc_src_e  = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD_BEEF;
      #1;
      checkOutput("no req in DROP", {31'b0, req_valid}, 32'd0);
      checkOutput("DROP addr is target", req_addr, 32'h40);
      tick();
      rsp_valid = 1'b0;
      #1;
      checkOutput("stale rsp discarded", {31'b0, valid_d}, 32'd0);
      applyStimulus(32'h40);

      // Redirect coincident with the response in WAIT -> data discarded.
      req_ready = 1'b1;
      #1;
      checkOutput("wait-redirect addr", req_addr, 32'h44);
      tick();
      req_ready   = 1'b0;
      rsp_valid   = 1'b1;
      rsp_data    = mem_word(32'h44);
      pc_src_e    = 1'b1;
      pc_target_e = 32'h80;
      tick();
      rsp_valid = 1'b0;
      pc_src_e  = 1'b0;
      #1;
      checkOutput("WAIT redirect no delivery", {31'b0, valid_d}, 32'd0);
      checkOutput("WAIT redirect addr", req_addr, 32'h80);

      // Redirect in REQ without handshake, then StallF withholds the request.
      req_ready   = 1'b0;
      pc_src_e    = 1'b1;
      pc_target_e = 32'h100;
      tick();
      pc_src_e = 1'b0;
      stall_f  = 1'b1;
      #1;
      checkOutput("StallF withholds req", {31'b0, req_valid}, 32'd0);
      checkOutput("REQ redirect addr", req_addr, 32'h100);
      tick();
      stall_f = 1'b0;
      applyStimulus(32'h100);

      // FlushD together with StallD clears decode to a bubble.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_d = 1'b1;
      tick();
      flush_d = 1'b0;
      stall_d = 1'b0;
      stall_f = 1'b0;
      checkOutput("flush InstrD", instr_d, 32'h0000_0013);
      checkOutput("flush ValidD", {31'b0, valid_d}, 32'd0);
      checkOutput("flush PCD held", pc_d, 32'h100);

      // PC wrap-around on the second instance (RESET_PC = FFFF_FFFC).
      w_req_ready = 1'b1;
      #1;
      checkOutput("wrap first addr", w_req_addr, 32'hFFFF_FFFC);
      tick();
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_data  = mem_word(32'hFFFF_FFFC);
      tick();
      w_rsp_valid = 1'b0;
      #1;
      checkOutput("wrap ValidD", {31'b0, w_valid_d}, 32'd1);
      checkOutput("wrap InstrD", w_instr_d, mem_word(32'hFFFF_FFFC));
      checkOutput("wrap PCD", w_pc_d, 32'hFFFF_FFFC);
      checkOutput("wrap PCPlus4D", w_pc_plus4_d, 32'h0);
      checkOutput("wrap second addr", w_req_addr, 32'h0);

      tick();
      tick();
      checkOutput("scoreboard drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
